// File: rtl/min_max_pkg.sv
// rtl/min_max_pkg.sv - shared types and defaults for the min/max index finder
// Purpose : one-hot state encoding and default geometry shared by the
//           finder top and its comparator.
// Contents: DEF_DATA_W, DEF_DEPTH, state_t (INI/LOAD/COMP/DONE).
package min_max_pkg;

   localparam int DEF_DATA_W = 8;
   localparam int DEF_DEPTH  = 16;

   // One-hot so each state bit can drive a Q* output directly.
   typedef enum logic [3:0] {
      INI  = 4'b0001,
      LOAD = 4'b0010,
      COMP = 4'b0100,
      DONE = 4'b1000
   } state_t;

endpackage

// File: rtl/mm_cmp.sv
// rtl/mm_cmp.sv - combinational magnitude comparator, unsigned or signed
// Purpose : strict greater/less compare of two W-bit operands.
// Ports   : i_a, i_b        operands (W bits each)
//           i_signed_mode   1 = two's-complement compare, 0 = unsigned
//           o_gt            i_a > i_b
//           o_lt            i_a < i_b
module mm_cmp #(
   parameter int W = 8
) (
   input  logic [W-1:0] i_a,
   input  logic [W-1:0] i_b,
   input  logic         i_signed_mode,
   output logic         o_gt,
   output logic         o_lt
);

   always_comb begin
      o_gt = 1'b0;
      o_lt = 1'b0;
      if (i_signed_mode) begin
         o_gt = $signed(i_a) > $signed(i_b);
         o_lt = $signed(i_a) < $signed(i_b);
      end else begin
         o_gt = i_a > i_b;
         o_lt = i_a < i_b;
      end
   end

endmodule

// File: rtl/min_max_idx_finder.sv
// rtl/min_max_idx_finder.sv - DEPTH x DATA_W array scanner reporting min/max and their indices
// Purpose : array loaded through a write port; on Start scans the first Len
//           entries one per clock and holds Max/Min/indices in DONE until Ack.
// Ports   : Clk, Reset (sync, active-high)
//           Wr_en/Wr_addr/Wr_data   array write port (INI or DONE only)
//           Start/Len/Signed_mode   scan request, sampled in INI
//           Ack                     release from DONE
//           Max/Min/Max_idx/Min_idx results, valid while Qd=1
//           Err                     last Start carried an illegal Len
//           Qi/Ql/Qc/Qd             one-hot state INI/LOAD/COMP/DONE
module min_max_idx_finder
   import min_max_pkg::*;
#(
   parameter  int DATA_W = DEF_DATA_W,
   parameter  int DEPTH  = DEF_DEPTH,
   localparam int ADDR_W = $clog2(DEPTH)
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              Wr_en,
   input  logic [ADDR_W-1:0] Wr_addr,
   input  logic [DATA_W-1:0] Wr_data,
   input  logic              Start,
   input  logic [ADDR_W:0]   Len,
   input  logic              Signed_mode,
   input  logic              Ack,
   output logic [DATA_W-1:0] Max,
   output logic [DATA_W-1:0] Min,
   output logic [ADDR_W-1:0] Max_idx,
   output logic [ADDR_W-1:0] Min_idx,
   output logic              Err,
   output logic              Qi,
   output logic              Ql,
   output logic              Qc,
   output logic              Qd
);

   localparam logic [ADDR_W:0] C_DEPTH = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0] C_ONE   = {{ADDR_W{1'b0}}, 1'b1};

   state_t              r_state;
   state_t              w_next;
   logic [DATA_W-1:0]   r_mem [DEPTH];
   logic [DATA_W-1:0]   r_max;
   logic [DATA_W-1:0]   r_min;
   logic [ADDR_W-1:0]   r_max_idx;
   logic [ADDR_W-1:0]   r_min_idx;
   logic                r_err;
   logic [ADDR_W:0]     r_i;
   logic [ADDR_W:0]     r_len;
   logic                r_sgn;

   logic [DATA_W-1:0]   w_elem;
   logic                w_gt_max;
   logic                w_lt_min;
   logic                w_unused_max_lt;
   logic                w_unused_min_gt;
   logic                w_len_ok;
   logic                w_last;
   logic                w_wr_ok;

   assign w_len_ok = (Len != '0) && (Len <= C_DEPTH);
   assign w_last   = (r_i == r_len - C_ONE);
   // r_i stays below DEPTH while in COMP, so the low bits are a valid index.
   assign w_elem   = r_mem[r_i[ADDR_W-1:0]];
   // Writes are locked out during a scan so it sees a stable array.
   assign w_wr_ok  = Wr_en && ((r_state == INI) || (r_state == DONE))
                     && ({1'b0, Wr_addr} < C_DEPTH);

   mm_cmp #(.W(DATA_W)) u_cmp_max (
      .i_a           (w_elem),
      .i_b           (r_max),
      .i_signed_mode (r_sgn),
      .o_gt          (w_gt_max),
      .o_lt          (w_unused_max_lt)
   );

   mm_cmp #(.W(DATA_W)) u_cmp_min (
      .i_a           (w_elem),
      .i_b           (r_min),
      .i_signed_mode (r_sgn),
      .o_gt          (w_unused_min_gt),
      .o_lt          (w_lt_min)
   );

   // Array contents are deliberately not reset.
   always_ff @(posedge Clk) begin
      if (w_wr_ok) r_mem[Wr_addr] <= Wr_data;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         INI:     if (Start) w_next = w_len_ok ? LOAD : DONE;
         LOAD:    w_next = (r_len == C_ONE) ? DONE : COMP;
         COMP:    if (w_last) w_next = DONE;
         DONE:    if (Ack) w_next = INI;
         default: w_next = INI;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_state   <= INI;
         r_max     <= '0;
         r_min     <= '0;
         r_max_idx <= '0;
         r_min_idx <= '0;
         r_err     <= 1'b0;
         r_i       <= '0;
         r_len     <= '0;
         r_sgn     <= 1'b0;
      end else begin
         r_state <= w_next;
         case (r_state)
            INI: begin
               r_i <= '0;
               if (Start) begin
                  r_len <= Len;
                  r_sgn <= Signed_mode;
                  // Illegal Len flags Err and leaves prior results untouched.
                  r_err <= !w_len_ok;
               end
            end
            LOAD: begin
               r_max     <= r_mem[0];
               r_min     <= r_mem[0];
               r_max_idx <= '0;
               r_min_idx <= '0;
               r_i       <= C_ONE;
            end
            COMP: begin
               // Strict compares keep the earliest index on ties.
               if (w_gt_max) begin
                  r_max     <= w_elem;
                  r_max_idx <= r_i[ADDR_W-1:0];
               end
               if (w_lt_min) begin
                  r_min     <= w_elem;
                  r_min_idx <= r_i[ADDR_W-1:0];
               end
               r_i <= r_i + C_ONE;
            end
            default: ;
         endcase
      end
   end

   assign Max     = r_max;
   assign Min     = r_min;
   assign Max_idx = r_max_idx;
   assign Min_idx = r_min_idx;
   assign Err     = r_err;
   assign Qi      = r_state[0];
   assign Ql      = r_state[1];
   assign Qc      = r_state[2];
   assign Qd      = r_state[3];

endmodule

// File: tb/tb_min_max_idx_finder.sv
// tb/tb_min_max_idx_finder.sv - self-checking bench for min_max_idx_finder
module tb_min_max_idx_finder;

   logic       Clk = 1'b0;
   logic       Reset;
   logic       Wr_en;
   logic [3:0] Wr_addr;
   logic [7:0] Wr_data;
   logic       Start;
   logic [4:0] Len;
   logic       Signed_mode;
   logic       Ack;
   logic [7:0] Max;
   logic [7:0] Min;
   logic [3:0] Max_idx;
   logic [3:0] Min_idx;
   logic       Err;
   logic       Qi;
   logic       Ql;
   logic       Qc;
   logic       Qd;

   int n_cmp  = 0;
   int n_fail = 0;

   typedef struct packed {
      logic [7:0] mx;
      logic [7:0] mn;
      logic [3:0] mxi;
      logic [3:0] mni;
      logic       err;
   } exp_t;

   exp_t sb_q[$];

   min_max_idx_finder dut (
      .Clk         (Clk),
      .Reset       (Reset),
      .Wr_en       (Wr_en),
      .Wr_addr     (Wr_addr),
      .Wr_data     (Wr_data),
      .Start       (Start),
      .Len         (Len),
      .Signed_mode (Signed_mode),
      .Ack         (Ack),
      .Max         (Max),
      .Min         (Min),
      .Max_idx     (Max_idx),
      .Min_idx     (Min_idx),
      .Err         (Err),
      .Qi          (Qi),
      .Ql          (Ql),
      .Qc          (Qc),
      .Qd          (Qd)
   );

   always #5 Clk = ~Clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_cmp++;
      assert (obs === exp_v) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic wr(input logic [3:0] a, input logic [7:0] d);
      Wr_en = 1'b1; Wr_addr = a; Wr_data = d;
      tick();
      Wr_en = 1'b0;
   endtask

   task automatic push(input logic [7:0] mx, input logic [7:0] mn,
                       input logic [3:0] mxi, input logic [3:0] mni, input logic err);
      exp_t e;
      e.mx = mx; e.mn = mn; e.mxi = mxi; e.mni = mni; e.err = err;
      sb_q.push_back(e);
   endtask

   // Drives Start, counts edges after the sampling edge until Qd, then pops
   // the scoreboard. drop_wr attempts a write to index 5 while in COMP.
   task automatic run_scan(input logic [4:0] len, input logic sgn, input bit drop_wr);
      int   cnt;
      int   exp_lat;
      exp_t e;
      exp_lat = (len >= 5'd1 && len <= 5'd16) ? int'(len) : 0;
      Len = len; Signed_mode = sgn; Start = 1'b1;
      tick();
      Start = 1'b0;
      cnt = 0;
      while (!Qd && cnt < 64) begin
         if (drop_wr && cnt == 3) begin
            Wr_en = 1'b1; Wr_addr = 4'd5; Wr_data = 8'hFF;
         end else begin
            Wr_en = 1'b0;
         end
         tick();
         cnt++;
      end
      Wr_en = 1'b0;
      chk("latency", cnt, exp_lat);
      if (sb_q.size() == 0) begin
         chk("sb_empty", 32'd1, 32'd0);
      end else begin
         e = sb_q.pop_front();
         chk("max",     Max,     e.mx);
         chk("min",     Min,     e.mn);
         chk("max_idx", Max_idx, e.mxi);
         chk("min_idx", Min_idx, e.mni);
         chk("err",     Err,     e.err);
      end
   endtask

   task automatic do_ack();
      Ack = 1'b1;
      tick();
      Ack = 1'b0;
      chk("ack_to_ini", Qi, 1'b1);
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, "_qi"},  Qi,      1'b1);
      chk({tag, "_qd"},  Qd,      1'b0);
      chk({tag, "_max"}, Max,     8'h00);
      chk({tag, "_min"}, Min,     8'h00);
      chk({tag, "_mxi"}, Max_idx, 4'h0);
      chk({tag, "_mni"}, Min_idx, 4'h0);
      chk({tag, "_err"}, Err,     1'b0);
   endtask

   initial begin
      Reset = 1'b1; Wr_en = 1'b0; Wr_addr = '0; Wr_data = '0;
      Start = 1'b0; Len = '0; Signed_mode = 1'b0; Ack = 1'b0;
      tick(); tick();
      Reset = 1'b0;
      chk_reset_state("reset");

      // Ramp 0x10..0x1F with 0x05 at 7 and 0xF0 at 12.
      for (int i = 0; i < 16; i++) begin
         if (i == 7)       wr(4'(i), 8'h05);
         else if (i == 12) wr(4'(i), 8'hF0);
         else              wr(4'(i), 8'(8'h10 + i));
      end

      push(8'hF0, 8'h05, 4'd12, 4'd7, 1'b0);
      run_scan(5'd16, 1'b0, 1'b0);
      do_ack();

      push(8'h1F, 8'hF0, 4'd15, 4'd12, 1'b0);
      run_scan(5'd16, 1'b1, 1'b0);
      do_ack();

      // Illegal lengths: Err set, previous results retained.
      push(8'h1F, 8'hF0, 4'd15, 4'd12, 1'b1);
      run_scan(5'd0, 1'b0, 1'b0);
      do_ack();
      push(8'h1F, 8'hF0, 4'd15, 4'd12, 1'b1);
      run_scan(5'd17, 1'b0, 1'b0);
      do_ack();

      // Duplicated extremes: first occurrence wins.
      for (int i = 0; i < 16; i++) begin
         if (i == 2 || i == 9)       wr(4'(i), 8'hAA);
         else if (i == 4 || i == 11) wr(4'(i), 8'h01);
         else                        wr(4'(i), 8'h50);
      end
      push(8'hAA, 8'h01, 4'd2, 4'd4, 1'b0);
      run_scan(5'd16, 1'b0, 1'b0);

      // Hold in DONE with Ack low; a Start pulse must be ignored.
      for (int k = 0; k < 5; k++) begin
         Start = (k == 2);
         Len   = 5'd5;
         tick();
         chk("hold_qd",  Qd,  1'b1);
         chk("hold_max", Max, 8'hAA);
      end
      Start = 1'b0;

      // Write in DONE is accepted; shows up in the Len=1 scan.
      wr(4'd0, 8'h3C);
      do_ack();
      push(8'h3C, 8'h3C, 4'd0, 4'd0, 1'b0);
      run_scan(5'd1, 1'b1, 1'b0);
      do_ack();

      // Write of 0xFF to index 5 during COMP must be dropped; rescan confirms.
      push(8'hAA, 8'h01, 4'd2, 4'd4, 1'b0);
      run_scan(5'd16, 1'b0, 1'b1);
      do_ack();
      push(8'hAA, 8'h01, 4'd2, 4'd4, 1'b0);
      run_scan(5'd16, 1'b0, 1'b0);
      do_ack();

      // Reset mid-COMP when I=6.
      Len = 5'd16; Signed_mode = 1'b0; Start = 1'b1;
      tick();
      Start = 1'b0;
      for (int k = 0; k < 6; k++) tick();
      chk("mid_qc", Qc, 1'b1);
      Reset = 1'b1;
      tick();
      Reset = 1'b0;
      chk_reset_state("midreset");

      // Full signed scan after reset: array kept its contents.
      push(8'h50, 8'hAA, 4'd1, 4'd2, 1'b0);
      run_scan(5'd16, 1'b1, 1'b0);
      do_ack();

      chk("sb_drained", sb_q.size(), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
